serial_add_ctrl: RTL



---
 rtl/serial_add_pkg.sv | 14 +
 rtl/half_adder.sv | 16 +
 rtl/serial_add_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and limits for the bit-serial adder controller.
//   state_t   : controller FSM states (IDLE, RUN, DONE)
//   MAX_WIDTH : largest supported operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder, used in pairs to form the shared full-add slice.
// Ports:
//   a, b  : input bits
//   sum   : a ^ b
//   carry : a & b
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder controller. Operand pairs are
// accepted over a valid/ready handshake, processed LSB-first one bit per clock
// through a full-add slice built from two half_adder instances, and the result
// is returned over a second valid/ready handshake.
//
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input; when set at the
// input handshake the block computes op_a - op_b (carry_out=1 means no borrow).
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : operand pair valid
//   in_ready  : controller can accept operands (IDLE)
//   op_a/op_b : operands
//   sub       : subtract request (only with SERIAL_ADD_SUB_EN)
//   out_valid : result valid (DONE)
//   out_ready : consumer accepts result
//   sum       : result bits, held until the next result
//   carry_out : final carry (unsigned overflow / not-borrow)
//   busy      : high in RUN or DONE
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next;
  logic             b_bit, last_bit;
  logic             ha0_s, ha0_c, ha1_s, ha1_c;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_r;
  // Subtraction is A + ~B + 1: invert B per bit, carry starts at 1.
  assign b_bit = b_sh[0] ^ sub_r;
`else
  assign b_bit = b_sh[0];
`endif

  half_adder u_ha0 (.a(a_sh[0]), .b(b_bit), .sum(ha0_s), .carry(ha0_c));
  half_adder u_ha1 (.a(ha0_s),   .b(carry), .sum(ha1_s), .carry(ha1_c));

  assign carry_next = ha0_c | ha1_c;
  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_next   = WIDTH'({ha1_s, res_sh} >> 1);
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // NOTE: the whole datapath is cleared on reset (it is a handful of flops,
  // not a memory array), so a result interrupted by reset is never visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_sh   <= op_a;
      b_sh   <= op_b;
      res_sh <= '0;
      cnt    <= '0;
`ifdef SERIAL_ADD_SUB_EN
      sub_r  <= sub;
      carry  <= sub;
`else
      carry  <= 1'b0;
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      carry  <= carry_next;
      cnt    <= cnt + 1'b1;
      // Published result registers change only on the final bit, so they
      // stay stable through DONE and after it until the next result.
      if (last_bit) begin
        sum       <= res_next;
        carry_out <= carry_next;
      end
    end
  end

endmodule
